// File: rtl/rotor_step_ctrl_pkg.sv
// Shared definitions for the rotor stepping controller: alphabet, notches,
// letter code type and FSM state encoding.
package rotor_step_ctrl_pkg;

  localparam int ALPHA_DEF  = 26;
  localparam int NOTCH1_DEF = 16;
  localparam int NOTCH2_DEF = 4;
  localparam int CODE_W     = 5;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_ENCODE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  function automatic code_t inc_pos(input code_t x, input int alpha);
    return (x == code_t'(alpha - 1)) ? '0 : x + code_t'(1);
  endfunction

  // Out-of-alphabet start positions are forced to 0 rather than wrapped.
  function automatic code_t clamp_pos(input code_t x, input int alpha);
    return (x >= code_t'(alpha)) ? '0 : x;
  endfunction

endpackage

// File: rtl/rotor_step_ctrl_if.sv
// Bus bundle between the rotor stepping controller and its environment
// (config, key input, datapath drive/return, cipher output, debug state).
interface rotor_step_ctrl_if;
  import rotor_step_ctrl_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and data is held while valid is up.
  logic   cfg_load;
  code_t  cfg_r1;
  code_t  cfg_r2;
  code_t  cfg_r3;
  logic   key_valid;
  code_t  key_in;
  logic   key_ready;
  code_t  enc_in;
  code_t  enc_r1;
  code_t  enc_r2;
  code_t  enc_r3;
  code_t  enc_out;
  logic   cipher_valid;
  code_t  cipher_out;
  logic   cipher_ready;
  logic   key_err;
  state_t dbg_state;

  modport master (
    input  cfg_load, cfg_r1, cfg_r2, cfg_r3, key_valid, key_in, enc_out, cipher_ready,
    output key_ready, enc_in, enc_r1, enc_r2, enc_r3, cipher_valid, cipher_out, key_err,
           dbg_state
  );

  modport slave (
    output cfg_load, cfg_r1, cfg_r2, cfg_r3, key_valid, key_in, enc_out, cipher_ready,
    input  key_ready, enc_in, enc_r1, enc_r2, enc_r3, cipher_valid, cipher_out, key_err,
           dbg_state
  );

endinterface

// File: rtl/rotor_step_ctrl_stepper.sv
// Combinational odometer step of the three rotors, including the middle-rotor
// double step.
module rotor_stepper
  import rotor_step_ctrl_pkg::*;
#(
  parameter int ALPHA  = ALPHA_DEF,
  parameter int NOTCH1 = NOTCH1_DEF,
  parameter int NOTCH2 = NOTCH2_DEF
) (
  input  code_t p1_i,
  input  code_t p2_i,
  input  code_t p3_i,
  output code_t n1_o,
  output code_t n2_o,
  output code_t n3_o
);

  logic r1_at_notch;
  logic r2_at_notch;

  assign r1_at_notch = (p1_i == code_t'(NOTCH1));
  assign r2_at_notch = (p2_i == code_t'(NOTCH2));

  // r2 at its notch steps itself as well as r3: the double step.
  assign n1_o = inc_pos(p1_i, ALPHA);
  assign n2_o = (r1_at_notch || r2_at_notch) ? inc_pos(p2_i, ALPHA) : p2_i;
  assign n3_o = r2_at_notch ? inc_pos(p3_i, ALPHA) : p3_i;

endmodule

// File: rtl/rotor_step_ctrl.sv
// Sequencer for the rotor/reflector datapath: accepts a letter, steps the
// rotors, captures the datapath result and offers it on a valid/ready output.
module rotor_step_ctrl
  import rotor_step_ctrl_pkg::*;
#(
  parameter int ALPHA  = ALPHA_DEF,
  parameter int NOTCH1 = NOTCH1_DEF,
  parameter int NOTCH2 = NOTCH2_DEF
) (
  input  logic              clk,
  input  logic              rst,
  rotor_step_ctrl_if.master bus
);

  state_t state_q, state_d;
  code_t  r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  code_t  enc_in_q, enc_in_d;
  code_t  cipher_out_q, cipher_out_d;
  logic   cipher_valid_q, cipher_valid_d;
  logic   key_err_q, key_err_d;
  logic   key_ready_c;
  code_t  n1, n2, n3;

  rotor_stepper #(
    .ALPHA (ALPHA),
    .NOTCH1(NOTCH1),
    .NOTCH2(NOTCH2)
  ) u_stepper (
    .p1_i(r1_q),
    .p2_i(r2_q),
    .p3_i(r3_q),
    .n1_o(n1),
    .n2_o(n2),
    .n3_o(n3)
  );

  assign key_ready_c = (state_q == ST_IDLE) && !bus.cfg_load && !rst;

  always_comb begin
    state_d        = state_q;
    r1_d           = r1_q;
    r2_d           = r2_q;
    r3_d           = r3_q;
    enc_in_d       = enc_in_q;
    cipher_out_d   = cipher_out_q;
    cipher_valid_d = cipher_valid_q;
    key_err_d      = 1'b0;
    // A config load wins over everything and drops any letter in flight.
    if (bus.cfg_load) begin
      r1_d           = clamp_pos(bus.cfg_r1, ALPHA);
      r2_d           = clamp_pos(bus.cfg_r2, ALPHA);
      r3_d           = clamp_pos(bus.cfg_r3, ALPHA);
      cipher_valid_d = 1'b0;
      state_d        = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.key_valid && key_ready_c) begin
            if (bus.key_in >= code_t'(ALPHA)) begin
              key_err_d = 1'b1;
            end else begin
              enc_in_d = bus.key_in;
              state_d  = ST_STEP;
            end
          end
        end
        ST_STEP: begin
          r1_d    = n1;
          r2_d    = n2;
          r3_d    = n3;
          state_d = ST_ENCODE;
        end
        ST_ENCODE: begin
          cipher_out_d   = bus.enc_out;
          cipher_valid_d = 1'b1;
          state_d        = ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.cipher_ready) begin
            cipher_valid_d = 1'b0;
            state_d        = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      r1_q           <= '0;
      r2_q           <= '0;
      r3_q           <= '0;
      enc_in_q       <= '0;
      cipher_out_q   <= '0;
      cipher_valid_q <= 1'b0;
      key_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      r1_q           <= r1_d;
      r2_q           <= r2_d;
      r3_q           <= r3_d;
      enc_in_q       <= enc_in_d;
      cipher_out_q   <= cipher_out_d;
      cipher_valid_q <= cipher_valid_d;
      key_err_q      <= key_err_d;
    end
  end

  assign bus.key_ready    = key_ready_c;
  assign bus.enc_in       = enc_in_q;
  assign bus.enc_r1       = r1_q;
  assign bus.enc_r2       = r2_q;
  assign bus.enc_r3       = r3_q;
  assign bus.cipher_valid = cipher_valid_q;
  assign bus.cipher_out   = cipher_out_q;
  assign bus.key_err      = key_err_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_rotor_step_ctrl.sv
// Bench for rotor_step_ctrl: directed scenarios plus a randomized run scored
// against an arithmetic rotor model and a stand-in encryption datapath.
module tb_rotor_step_ctrl;
  import rotor_step_ctrl_pkg::*;

  localparam int ALPHA  = 26;
  localparam int NOTCH1 = 16;
  localparam int NOTCH2 = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   m_r1, m_r2, m_r3;
  logic [4:0] exp_q[$];

  rotor_step_ctrl_if bus();

  rotor_step_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1, "watchdog");
  end

  // Stand-in datapath: any fixed mix of letter and positions will do.
  function automatic logic [4:0] dp_model(input int c, input int a, input int b, input int d);
    int v;
    v = (c + 3 * a + 5 * b + 7 * d + 11) % ALPHA;
    return v[4:0];
  endfunction

  assign bus.enc_out = dp_model(int'(bus.enc_in), int'(bus.enc_r1), int'(bus.enc_r2),
                                int'(bus.enc_r3));

  // Reference stepping: an odometer where r2 also moves when it sits on its notch.
  function automatic void model_step();
    bit s2, s3;
    s2 = (m_r1 == NOTCH1) || (m_r2 == NOTCH2);
    s3 = (m_r2 == NOTCH2);
    m_r1 = (m_r1 + 1) % ALPHA;
    if (s2) m_r2 = (m_r2 + 1) % ALPHA;
    if (s3) m_r3 = (m_r3 + 1) % ALPHA;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_cfg(input int a, input int b, input int c);
    logic [4:0] va, vb, vc;
    va = a[4:0]; vb = b[4:0]; vc = c[4:0];
    @(negedge clk);
    bus.cfg_r1 = va; bus.cfg_r2 = vb; bus.cfg_r3 = vc; bus.cfg_load = 1'b1;
    @(negedge clk);
    bus.cfg_load = 1'b0;
    m_r1 = (a >= ALPHA) ? 0 : a;
    m_r2 = (b >= ALPHA) ? 0 : b;
    m_r3 = (c >= ALPHA) ? 0 : c;
  endtask

  // Returns at the falling edge right after the accepting rising edge.
  task automatic send_key(input int code);
    int n;
    logic [4:0] v;
    n = 0;
    v = code[4:0];
    @(negedge clk);
    bus.key_valid = 1'b1; bus.key_in = v;
    while (!bus.key_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin bad++; $display("FAIL key_accept_timeout got=%0d want<50", n); end
    @(posedge clk);
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  // lat counts falling edges after the accept edge until cipher_valid is seen.
  task automatic take_cipher(input int delay, output logic [4:0] data, output int lat);
    lat = 0;
    while (!bus.cipher_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    data = bus.cipher_out;
    repeat (delay) @(negedge clk);
    bus.cipher_ready = 1'b1;
    @(negedge clk);
    bus.cipher_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.enc_r1 !== 5'd0) begin bad++; $display("FAIL rst_r1 got=%0d want=0", bus.enc_r1); end
    total++; if (bus.enc_r2 !== 5'd0) begin bad++; $display("FAIL rst_r2 got=%0d want=0", bus.enc_r2); end
    total++; if (bus.enc_r3 !== 5'd0) begin bad++; $display("FAIL rst_r3 got=%0d want=0", bus.enc_r3); end
    total++; if (bus.enc_in !== 5'd0) begin bad++; $display("FAIL rst_enc_in got=%0d want=0", bus.enc_in); end
    total++; if (bus.cipher_out !== 5'd0) begin bad++; $display("FAIL rst_cipher_out got=%0d want=0", bus.cipher_out); end
    total++; if (bus.cipher_valid !== 1'b0) begin bad++; $display("FAIL rst_cipher_valid got=%b want=0", bus.cipher_valid); end
    total++; if (bus.key_err !== 1'b0) begin bad++; $display("FAIL rst_key_err got=%b want=0", bus.key_err); end
    total++; if (bus.key_ready !== 1'b0) begin bad++; $display("FAIL rst_key_ready got=%b want=0", bus.key_ready); end
    total++; if (bus.dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d want=0", bus.dbg_state); end
    rst = 1'b0;
    m_r1 = 0; m_r2 = 0; m_r3 = 0;
    @(negedge clk);
    total++; if (bus.key_ready !== 1'b1) begin bad++; $display("FAIL post_rst_key_ready got=%b want=1", bus.key_ready); end
  endtask

  task automatic test_basic();
    logic [4:0] data;
    int lat;
    send_key(0);
    total++; if (bus.cipher_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_early got=%b want=0", bus.cipher_valid); end
    take_cipher(0, data, lat);
    // Counting the accept edge itself, valid shows after the third edge.
    total++; if (lat !== 2) begin bad++; $display("FAIL basic_latency got=%0d want=2", lat); end
    total++; if (data !== dp_model(0, 1, 0, 0)) begin bad++; $display("FAIL basic_cipher got=%0d want=%0d", data, dp_model(0, 1, 0, 0)); end
    total++; if ({bus.enc_r1, bus.enc_r2, bus.enc_r3} !== {5'd1, 5'd0, 5'd0}) begin bad++; $display("FAIL basic_pos got=%0d,%0d,%0d want=1,0,0", bus.enc_r1, bus.enc_r2, bus.enc_r3); end
    total++; if (bus.cipher_valid !== 1'b0 || bus.key_ready !== 1'b1) begin bad++; $display("FAIL basic_release got=v%b r%b want=v0 r1", bus.cipher_valid, bus.key_ready); end
    model_step();
  endtask

  task automatic test_double_step();
    int e1[3] = '{16, 17, 18};
    int e2[3] = '{3, 4, 5};
    int e3[3] = '{0, 0, 1};
    logic [4:0] data;
    int lat, code;
    do_cfg(15, 3, 0);
    for (int k = 0; k < 3; k++) begin
      code = $urandom_range(0, ALPHA - 1);
      send_key(code);
      model_step();
      take_cipher(0, data, lat);
      total++; if (int'(bus.enc_r1) != e1[k] || int'(bus.enc_r2) != e2[k] || int'(bus.enc_r3) != e3[k]) begin
        bad++; $display("FAIL dstep_pos%0d got=%0d,%0d,%0d want=%0d,%0d,%0d", k, bus.enc_r1, bus.enc_r2, bus.enc_r3, e1[k], e2[k], e3[k]); end
      total++; if (data !== dp_model(code, e1[k], e2[k], e3[k])) begin bad++; $display("FAIL dstep_cipher%0d got=%0d want=%0d", k, data, dp_model(code, e1[k], e2[k], e3[k])); end
    end
  endtask

  task automatic test_wrap();
    logic [4:0] data;
    int lat;
    do_cfg(25, 25, 25);
    send_key(7);
    model_step();
    take_cipher(0, data, lat);
    total++; if ({bus.enc_r1, bus.enc_r2, bus.enc_r3} !== {5'd0, 5'd25, 5'd25}) begin bad++; $display("FAIL wrap1_pos got=%0d,%0d,%0d want=0,25,25", bus.enc_r1, bus.enc_r2, bus.enc_r3); end
    total++; if (data !== dp_model(7, 0, 25, 25)) begin bad++; $display("FAIL wrap1_cipher got=%0d want=%0d", data, dp_model(7, 0, 25, 25)); end
    do_cfg(16, 25, 25);
    send_key(25);
    model_step();
    take_cipher(0, data, lat);
    total++; if ({bus.enc_r1, bus.enc_r2, bus.enc_r3} !== {5'd17, 5'd0, 5'd25}) begin bad++; $display("FAIL wrap2_pos got=%0d,%0d,%0d want=17,0,25", bus.enc_r1, bus.enc_r2, bus.enc_r3); end
    total++; if (data !== dp_model(25, 17, 0, 25)) begin bad++; $display("FAIL wrap2_cipher got=%0d want=%0d", data, dp_model(25, 17, 0, 25)); end
  endtask

  task automatic test_backpressure();
    logic [4:0] want;
    int code, errs;
    code = $urandom_range(0, ALPHA - 1);
    send_key(code);
    model_step();
    want = dp_model(code, m_r1, m_r2, m_r3);
    repeat (2) @(negedge clk);
    total++; if (bus.cipher_valid !== 1'b1 || bus.cipher_out !== want) begin bad++; $display("FAIL bp_first got=v%b %0d want=v1 %0d", bus.cipher_valid, bus.cipher_out, want); end
    bus.key_valid = 1'b1; bus.key_in = 5'd3;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cipher_valid !== 1'b1 || bus.cipher_out !== want || bus.key_ready !== 1'b0 ||
          int'(bus.enc_r1) != m_r1 || int'(bus.enc_r2) != m_r2 || int'(bus.enc_r3) != m_r3) errs++;
    end
    bus.key_valid = 1'b0;
    total++; if (errs != 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles want=0", errs); end
    bus.cipher_ready = 1'b1;
    @(negedge clk);
    bus.cipher_ready = 1'b0;
    total++; if (bus.cipher_valid !== 1'b0 || bus.key_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=v%b r%b want=v0 r1", bus.cipher_valid, bus.key_ready); end
  endtask

  task automatic test_bad_key();
    logic [4:0] data, prev_in;
    int lat, code;
    prev_in = bus.enc_in;
    send_key(26);
    total++; if (bus.key_err !== 1'b1) begin bad++; $display("FAIL badkey_err got=%b want=1", bus.key_err); end
    total++; if (bus.dbg_state !== ST_IDLE) begin bad++; $display("FAIL badkey_state got=%0d want=0", bus.dbg_state); end
    @(negedge clk);
    total++; if (bus.key_err !== 1'b0) begin bad++; $display("FAIL badkey_pulse got=%b want=0", bus.key_err); end
    total++; if (bus.cipher_valid !== 1'b0) begin bad++; $display("FAIL badkey_valid got=%b want=0", bus.cipher_valid); end
    total++; if (int'(bus.enc_r1) != m_r1 || int'(bus.enc_r2) != m_r2 || int'(bus.enc_r3) != m_r3 || bus.enc_in !== prev_in) begin
      bad++; $display("FAIL badkey_nostep got=%0d,%0d,%0d in%0d want=%0d,%0d,%0d in%0d", bus.enc_r1, bus.enc_r2, bus.enc_r3, bus.enc_in, m_r1, m_r2, m_r3, prev_in); end
    send_key(31);
    total++; if (bus.key_err !== 1'b1) begin bad++; $display("FAIL badkey31_err got=%b want=1", bus.key_err); end
    code = $urandom_range(0, ALPHA - 1);
    send_key(code);
    model_step();
    take_cipher(0, data, lat);
    total++; if (lat !== 2 || data !== dp_model(code, m_r1, m_r2, m_r3)) begin bad++; $display("FAIL badkey_next got=lat%0d %0d want=lat2 %0d", lat, data, dp_model(code, m_r1, m_r2, m_r3)); end
  endtask

  task automatic test_cfg_abort();
    send_key(5);
    @(negedge clk);
    total++; if (bus.dbg_state !== ST_ENCODE) begin bad++; $display("FAIL abort_enc_state got=%0d want=2", bus.dbg_state); end
    bus.cfg_r1 = 5'd7; bus.cfg_r2 = 5'd8; bus.cfg_r3 = 5'd9; bus.cfg_load = 1'b1;
    bus.key_valid = 1'b1; bus.key_in = 5'd3;
    #1;
    total++; if (bus.key_ready !== 1'b0) begin bad++; $display("FAIL abort_key_ready got=%b want=0", bus.key_ready); end
    @(negedge clk);
    bus.cfg_load = 1'b0; bus.key_valid = 1'b0;
    m_r1 = 7; m_r2 = 8; m_r3 = 9;
    total++; if (bus.cipher_valid !== 1'b0 || bus.dbg_state !== ST_IDLE) begin bad++; $display("FAIL abort_enc got=v%b s%0d want=v0 s0", bus.cipher_valid, bus.dbg_state); end
    total++; if ({bus.enc_r1, bus.enc_r2, bus.enc_r3} !== {5'd7, 5'd8, 5'd9}) begin bad++; $display("FAIL abort_enc_pos got=%0d,%0d,%0d want=7,8,9", bus.enc_r1, bus.enc_r2, bus.enc_r3); end
    repeat (3) @(negedge clk);
    total++; if (bus.cipher_valid !== 1'b0) begin bad++; $display("FAIL abort_enc_late got=%b want=0", bus.cipher_valid); end

    send_key(9);
    repeat (2) @(negedge clk);
    total++; if (bus.cipher_valid !== 1'b1) begin bad++; $display("FAIL abort_hold_pre got=%b want=1", bus.cipher_valid); end
    do_cfg(30, 2, 25);
    total++; if (bus.cipher_valid !== 1'b0) begin bad++; $display("FAIL abort_hold got=%b want=0", bus.cipher_valid); end
    total++; if ({bus.enc_r1, bus.enc_r2, bus.enc_r3} !== {5'd0, 5'd2, 5'd25}) begin bad++; $display("FAIL abort_hold_pos got=%0d,%0d,%0d want=0,2,25", bus.enc_r1, bus.enc_r2, bus.enc_r3); end

    send_key(12);
    repeat (2) @(negedge clk);
    total++; if (bus.cipher_valid !== 1'b1) begin bad++; $display("FAIL rst_hold_pre got=%b want=1", bus.cipher_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if ({bus.enc_r1, bus.enc_r2, bus.enc_r3, bus.enc_in, bus.cipher_out} !== 25'd0) begin
      bad++; $display("FAIL rst_mid_data got=%0d,%0d,%0d in%0d out%0d want=all 0", bus.enc_r1, bus.enc_r2, bus.enc_r3, bus.enc_in, bus.cipher_out); end
    total++; if (bus.cipher_valid !== 1'b0 || bus.key_ready !== 1'b0 || bus.key_err !== 1'b0) begin
      bad++; $display("FAIL rst_mid_ctrl got=v%b r%b e%b want=0,0,0", bus.cipher_valid, bus.key_ready, bus.key_err); end
    @(negedge clk);
    rst = 1'b0;
    m_r1 = 0; m_r2 = 0; m_r3 = 0;
  endtask

  task automatic test_random();
    logic [4:0] data, want;
    int lat, code, sel;
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        do_cfg($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      end else if (sel == 1) begin
        send_key($urandom_range(ALPHA, 31));
        @(negedge clk);
      end else begin
        code = $urandom_range(0, ALPHA - 1);
        send_key(code);
        model_step();
        exp_q.push_back(dp_model(code, m_r1, m_r2, m_r3));
        take_cipher($urandom_range(0, 3), data, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL rnd_latency it%0d got=%0d want=2", it, lat); end
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_scoreboard it%0d got=%0d want=queued entry", it, data);
        end else begin
          want = exp_q.pop_front();
          if (data !== want) begin bad++; $display("FAIL rnd_cipher it%0d got=%0d want=%0d", it, data, want); end
        end
      end
      total++; if (int'(bus.enc_r1) != m_r1 || int'(bus.enc_r2) != m_r2 || int'(bus.enc_r3) != m_r3) begin
        bad++; $display("FAIL rnd_pos it%0d got=%0d,%0d,%0d want=%0d,%0d,%0d", it, bus.enc_r1, bus.enc_r2, bus.enc_r3, m_r1, m_r2, m_r3); end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_leftover got=%0d want=0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.cfg_load = 1'b0; bus.cfg_r1 = '0; bus.cfg_r2 = '0; bus.cfg_r3 = '0;
    bus.key_valid = 1'b0; bus.key_in = '0; bus.cipher_ready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_double_step();
    test_wrap();
    test_backpressure();
    test_bad_key();
    test_cfg_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
